// File: rtl/range_normalizer.sv
`timescale 1ns/1ps
// range_normalizer
// Right-shifts a wide word one bit per clock until its top IN_W-OUT_W bits
// are clear, then publishes the OUT_W-bit mantissa together with the number
// of shifts applied. Words that still overflow after MAX_SHIFT shifts are
// reported as saturated (all-ones mantissa, out_sat=1). Results are held on
// the outputs until the next result, so downstream consumers never see
// intermediate shift-register contents.
//
// Ports:
//   clk        sole clock, rising edge
//   resetPort  asynchronous, active-low reset
//   in_data    word to normalise
//   in_valid   load request (ignored when CHANGE_DETECT=1)
//   in_ready   high while idle and able to accept a word
//   out_data   normalised mantissa, held until next result
//   out_shift  number of right shifts applied, held
//   out_sat    result saturated, held
//   out_valid  one-cycle pulse per new result
//   busy       high while shifting
module range_normalizer #(
    parameter int IN_W          = 40,
    parameter int OUT_W         = 28,
    parameter int CNT_W         = 4,
    parameter int MAX_SHIFT     = 12,
    parameter int ROUND         = 0,
    parameter int CHANGE_DETECT = 0
) (
    input  logic             clk,
    input  logic             resetPort,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_shift,
    output logic             out_sat,
    output logic             out_valid,
    output logic             busy
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_SHIFT);
    localparam logic [OUT_W-1:0] ALL_ONES = '1;
    localparam logic [OUT_W-1:0] MSB_ONLY = {1'b1, {(OUT_W-1){1'b0}}};

    state_t           state;
    logic [IN_W-1:0]  shreg;
    logic [IN_W-1:0]  last_loaded;
    logic [CNT_W-1:0] cnt;
    logic             rnd_bit;
    logic             load;
    logic             top_nz;

    // Result packing used by the helpers below: {sat, shift, mantissa}.
    function automatic logic [OUT_W+CNT_W:0] saturate();
        return {1'b1, MAX_CNT, ALL_ONES};
    endfunction

    function automatic logic [OUT_W:0] round_add(input logic [OUT_W-1:0] m,
                                                 input logic             b);
        return {1'b0, m} + {{OUT_W{1'b0}}, b};
    endfunction

    // A rounding carry out of the mantissa means it was all ones; one more
    // shift gives exactly MSB_ONLY, unless the shift budget is exhausted.
    function automatic logic [OUT_W+CNT_W:0] fit_result(input logic [OUT_W-1:0] mant,
                                                        input logic [CNT_W-1:0] n,
                                                        input logic             rb);
        logic [OUT_W:0] sum;
        sum = round_add(mant, (ROUND != 0) ? rb : 1'b0);
        if (!sum[OUT_W])
            return {1'b0, n, sum[OUT_W-1:0]};
        else if (n < MAX_CNT)
            return {1'b0, n + CNT_W'(1), MSB_ONLY};
        else
            return saturate();
    endfunction

    assign in_ready = (state == IDLE);
    assign busy     = (state == SHIFT);

    // In change-detect mode a word that changed while busy is still pending
    // here when IDLE is reached, so it is picked up then.
    assign load   = (CHANGE_DETECT != 0) ? (in_data != last_loaded) : in_valid;
    assign top_nz = |shreg[IN_W-1:OUT_W];

    always_ff @(posedge clk or negedge resetPort) begin
        if (!resetPort) begin
            state       <= IDLE;
            shreg       <= '0;
            last_loaded <= '0;
            cnt         <= '0;
            rnd_bit     <= 1'b0;
            out_data    <= '0;
            out_shift   <= '0;
            out_sat     <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        shreg       <= in_data;
                        last_loaded <= in_data;
                        cnt         <= '0;
                        rnd_bit     <= 1'b0;
                        state       <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (top_nz && (cnt < MAX_CNT)) begin
                        shreg   <= shreg >> 1;
                        rnd_bit <= shreg[0];
                        cnt     <= cnt + CNT_W'(1);
                    end else begin
                        {out_sat, out_shift, out_data} <= top_nz ? saturate()
                                                                 : fit_result(shreg[OUT_W-1:0], cnt, rnd_bit);
                        out_valid <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_range_normalizer.sv
`timescale 1ns/1ps
module tb_range_normalizer;

    logic        clk;
    logic        resetPort;
    logic [39:0] din   [4];
    logic        vin   [4];
    logic [27:0] od    [4];
    logic [3:0]  os    [4];
    logic        osat  [4];
    logic        ov    [4];
    logic        ord   [4];
    logic        obusy [4];

    // 0: defaults, 1: MAX_SHIFT=4, 2: ROUND=1, 3: CHANGE_DETECT=1
    range_normalizer u_def (
        .clk(clk), .resetPort(resetPort), .in_data(din[0]), .in_valid(vin[0]),
        .in_ready(ord[0]), .out_data(od[0]), .out_shift(os[0]), .out_sat(osat[0]),
        .out_valid(ov[0]), .busy(obusy[0]));

    range_normalizer #(.MAX_SHIFT(4)) u_sat (
        .clk(clk), .resetPort(resetPort), .in_data(din[1]), .in_valid(vin[1]),
        .in_ready(ord[1]), .out_data(od[1]), .out_shift(os[1]), .out_sat(osat[1]),
        .out_valid(ov[1]), .busy(obusy[1]));

    range_normalizer #(.ROUND(1)) u_rnd (
        .clk(clk), .resetPort(resetPort), .in_data(din[2]), .in_valid(vin[2]),
        .in_ready(ord[2]), .out_data(od[2]), .out_shift(os[2]), .out_sat(osat[2]),
        .out_valid(ov[2]), .busy(obusy[2]));

    range_normalizer #(.CHANGE_DETECT(1)) u_cd (
        .clk(clk), .resetPort(resetPort), .in_data(din[3]), .in_valid(vin[3]),
        .in_ready(ord[3]), .out_data(od[3]), .out_shift(os[3]), .out_sat(osat[3]),
        .out_valid(ov[3]), .busy(obusy[3]));

    typedef struct {
        int          id;
        int          cyc;
        logic [27:0] d;
        logic [3:0]  s;
        logic        sat;
    } exp_t;

    exp_t sbq[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   nval[4];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input int c, input logic [27:0] d,
                        input logic [3:0] s, input logic sat);
        exp_t e;
        e.id = i; e.cyc = c; e.d = d; e.s = s; e.sat = sat;
        sbq.push_back(e);
    endtask

    task automatic wait_ready(input int i);
        int t;
        t = 0;
        while (ord[i] !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk($sformatf("dut%0d_ready", i), ord[i], 1);
    endtask

    task automatic accept(input int i, input logic [39:0] d, output int c0);
        wait_ready(i);
        din[i] = d;
        vin[i] = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        vin[i] = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            @(negedge clk);
            #1;
            t++;
        end
        chk(tag, sbq.size(), 0);
    endtask

    // Result monitor: every out_valid must match the oldest pending
    // expectation for that instance, including the cycle it arrives in.
    initial begin
        int j;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (ov[i] === 1'b1) begin
                    nval[i]++;
                    j = -1;
                    for (int k = 0; k < sbq.size(); k++)
                        if (j < 0 && sbq[k].id == i) j = k;
                    chk($sformatf("dut%0d_expected_result", i), (j >= 0), 1);
                    if (j >= 0) begin
                        chk($sformatf("dut%0d_data", i),  od[i],   sbq[j].d);
                        chk($sformatf("dut%0d_shift", i), os[i],   sbq[j].s);
                        chk($sformatf("dut%0d_sat", i),   osat[i], sbq[j].sat);
                        chk($sformatf("dut%0d_cycle", i), cyc,     sbq[j].cyc);
                        sbq.delete(j);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        int nv0;
        resetPort = 1'b0;
        for (int i = 0; i < 4; i++) begin
            din[i] = '0;
            vin[i] = 1'b0;
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rst%0d_data", i),  od[i],    0);
            chk($sformatf("rst%0d_shift", i), os[i],    0);
            chk($sformatf("rst%0d_valid", i), ov[i],    0);
            chk($sformatf("rst%0d_ready", i), ord[i],   1);
            chk($sformatf("rst%0d_busy", i),  obusy[i], 0);
        end
        resetPort = 1'b1;
        @(negedge clk);

        // Small word: no shift, latency 1; then an immediate back-to-back accept.
        accept(0, 40'h0001234567, c);
        push(0, c + 1, 28'h1234567, 4'd0, 1'b0);
        drain("small_drain");
        accept(0, 40'h0000ABCDEF, c);
        push(0, c + 1, 28'h0ABCDEF, 4'd0, 1'b0);
        drain("b2b_drain");

        // Top bit set: 12 shifts, latency 13, busy throughout.
        accept(0, 40'h8000000000, c);
        push(0, c + 13, 28'h8000000, 4'd12, 1'b0);
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            chk($sformatf("shift_busy_%0d", k),  obusy[0], 1);
            chk($sformatf("shift_ready_%0d", k), ord[0],   0);
        end
        drain("max_shift_drain");

        // Zero word.
        accept(0, 40'h0, c);
        push(0, c + 1, 28'h0, 4'd0, 1'b0);
        drain("zero_drain");

        // Saturation with MAX_SHIFT=4.
        accept(1, 40'h8000000000, c);
        push(1, c + 5, 28'hFFFFFFF, 4'd4, 1'b1);
        drain("sat_drain");
        accept(1, 40'h0001234567, c);
        push(1, c + 1, 28'h1234567, 4'd0, 1'b0);
        drain("sat_small_drain");

        // Truncate vs round-half-up, and the rounding carry.
        accept(0, 40'h0010000001, c);
        push(0, c + 2, 28'h8000000, 4'd1, 1'b0);
        drain("trunc_drain");
        accept(2, 40'h0010000001, c);
        push(2, c + 2, 28'h8000001, 4'd1, 1'b0);
        drain("round_drain");
        accept(2, 40'h001FFFFFFF, c);
        push(2, c + 2, 28'h8000000, 4'd2, 1'b0);
        drain("round_carry_drain");

        // Change detect: input held at zero so far produced nothing.
        chk("cd_idle_count", nval[3], 0);
        @(negedge clk);
        din[3] = 40'h0001234567;
        @(posedge clk);
        #1;
        c = cyc;
        push(3, c + 1, 28'h1234567, 4'd0, 1'b0);
        drain("cd_first_drain");
        repeat (50) @(negedge clk);
        chk("cd_hold_count", nval[3], 1);

        // Change while busy is picked up on return to IDLE.
        din[3] = 40'h0010000001;
        @(posedge clk);
        #1;
        c = cyc;
        push(3, c + 2, 28'h8000000, 4'd1, 1'b0);
        @(negedge clk);
        chk("cd_busy", obusy[3], 1);
        din[3] = 40'h8000000000;
        push(3, c + 3 + 13, 28'h8000000, 4'd12, 1'b0);
        drain("cd_change_drain");
        chk("cd_total_count", nval[3], 3);

        // Reset in the middle of a long shift.
        nv0 = nval[0];
        accept(0, 40'h8000000000, c);
        repeat (3) @(negedge clk);
        resetPort = 1'b0;
        din[3] = 40'h0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst%0d_data", i),  od[i],    0);
            chk($sformatf("midrst%0d_shift", i), os[i],    0);
            chk($sformatf("midrst%0d_sat", i),   osat[i],  0);
            chk($sformatf("midrst%0d_valid", i), ov[i],    0);
            chk($sformatf("midrst%0d_ready", i), ord[i],   1);
            chk($sformatf("midrst%0d_busy", i),  obusy[i], 0);
        end
        resetPort = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", ord[0], 1);
        repeat (15) @(negedge clk);
        chk("post_rst_no_valid", nval[0], nv0);
        chk("post_rst_cd_quiet", nval[3], 3);
        accept(0, 40'h0001234567, c);
        push(0, c + 1, 28'h1234567, 4'd0, 1'b0);
        drain("post_rst_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
